// File: rtl/common_ddr_test_sequencer_if.sv
// Bus bundle between the DDR test sequencer and the board trigger / checker side.
// master = sequencer, slave = trigger logic plus checker instance.
interface common_ddr_test_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             abort;
  logic             chk_rstn;
  logic             chk_start;
  logic             chk_pass;
  logic             busy;
  logic             done;
  logic             all_pass;
  logic             timeout;
  logic [CNT_W-1:0] iter_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [2:0]       state;

  modport master (
    input  run, abort, chk_pass,
    output chk_rstn, chk_start, busy, done, all_pass, timeout,
           iter_cnt, pass_cnt, fail_cnt, state
  );

  modport slave (
    output run, abort, chk_pass,
    input  chk_rstn, chk_start, busy, done, all_pass, timeout,
           iter_cnt, pass_cnt, fail_cnt, state
  );
endinterface

// File: rtl/common_ddr_test_sequencer.sv
// Run controller for the DDR checker: resets/starts the checker for a number of watchdog-bounded passes.
// Optional macro DDR_SEQ_STOP_ON_FAIL_EN: end the run after the first timed-out pass.
module common_ddr_test_sequencer #(
  parameter int unsigned ITERATIONS     = 4,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 16
) (
  input logic                        axi_clk,
  input logic                        rstn,
  common_ddr_test_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHK_RST = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_NEXT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [31:0]      RST_LOAD = 32'(RST_CYCLES - 1);
  localparam logic [31:0]      WD_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      ITER_TGT = 32'(ITERATIONS);

  logic [2:0]       state_q, state_d;
  logic             run_q;
  logic             run_armed_q;
  logic [31:0]      rst_cnt_q, rst_cnt_d;
  logic [31:0]      wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic             aborted_q, aborted_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             chk_en_q, chk_en_d;
`ifdef DDR_SEQ_STOP_ON_FAIL_EN
  logic             pass_failed_q, pass_failed_d;
`endif

  logic run_rise;
  logic last_pass;
  logic stop_now;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // run_armed_q stays low after reset until run is seen low, so a level held through reset cannot start a run
  assign run_rise  = bus.run & ~run_q & run_armed_q;
  assign last_pass = (ITERATIONS != 0) && ((32'(iter_q) + 32'd1) == ITER_TGT);
`ifdef DDR_SEQ_STOP_ON_FAIL_EN
  assign stop_now  = last_pass | pass_failed_q;
`else
  assign stop_now  = last_pass;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    iter_d    = iter_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    aborted_d = aborted_q;
    busy_d    = busy_q;
    done_d    = done_q;
    chk_en_d  = chk_en_q;
`ifdef DDR_SEQ_STOP_ON_FAIL_EN
    pass_failed_d = pass_failed_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (run_rise) begin
          iter_d    = '0;
          pass_d    = '0;
          fail_d    = '0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          rst_cnt_d = RST_LOAD;
          state_d   = S_CHK_RST;
        end
      end

      S_CHK_RST: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (rst_cnt_q == 32'd0) begin
          chk_en_d = 1'b1;
          wd_cnt_d = 32'd0;
          state_d  = S_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q - 32'd1;
        end
      end

      // chk_pass is tested first so a pass on the last watchdog cycle still counts
      S_WAIT: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          chk_en_d  = 1'b0;
        end else begin
          wd_cnt_d = (wd_cnt_q == 32'hFFFF_FFFF) ? wd_cnt_q : wd_cnt_q + 32'd1;
          if (bus.chk_pass) begin
            pass_d   = satInc(pass_q);
            chk_en_d = 1'b0;
            state_d  = S_NEXT;
          end else if (wd_cnt_q == WD_LAST) begin
            fail_d    = satInc(fail_q);
            timeout_d = 1'b1;
            chk_en_d  = 1'b0;
            state_d   = S_NEXT;
`ifdef DDR_SEQ_STOP_ON_FAIL_EN
            pass_failed_d = 1'b1;
`endif
          end
        end
      end

      S_NEXT: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          iter_d = satInc(iter_q);
`ifdef DDR_SEQ_STOP_ON_FAIL_EN
          pass_failed_d = 1'b0;
`endif
          if (stop_now) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rst_cnt_d = RST_LOAD;
            state_d   = S_CHK_RST;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        chk_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      run_armed_q <= 1'b0;
      rst_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      iter_q      <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      timeout_q   <= 1'b0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chk_en_q    <= 1'b0;
`ifdef DDR_SEQ_STOP_ON_FAIL_EN
      pass_failed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= bus.run;
      run_armed_q <= run_armed_q | ~bus.run;
      rst_cnt_q   <= rst_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      iter_q      <= iter_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      chk_en_q    <= chk_en_d;
`ifdef DDR_SEQ_STOP_ON_FAIL_EN
      pass_failed_q <= pass_failed_d;
`endif
    end
  end

  assign bus.chk_rstn  = chk_en_q;
  assign bus.chk_start = chk_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.all_pass  = done_q & (fail_q == '0) & ~aborted_q;
  assign bus.timeout   = timeout_q;
  assign bus.iter_cnt  = iter_q;
  assign bus.pass_cnt  = pass_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.state     = state_q;

endmodule
